// File: rtl/pc_unit_pkg.sv
// Shared helpers and defaults for the multi-thread program-counter unit.
package pc_unit_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_INC         = 4;

  // Thread-id width; a single-thread build still carries a 1-bit id.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

  // Clears the low log2(inc) bits of a PC so redirects land on fetch granules.
  function automatic logic [63:0] align_mask(input int inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/fetch bundle between execute, the PC unit and instruction fetch.
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_THREADS = DEF_NUM_THREADS
);
  localparam int TID_W = tid_width(NUM_THREADS);

  logic                   stall;
  logic [NUM_THREADS-1:0] thread_en;
  logic                   redirect_valid;
  logic [TID_W-1:0]       redirect_tid;
  logic [WIDTH-1:0]       redirect_pc;
  logic                   fetch_valid;
  logic [TID_W-1:0]       fetch_tid;
  logic [WIDTH-1:0]       fetch_pc;

  modport master (
    output stall, thread_en, redirect_valid, redirect_tid, redirect_pc,
    input  fetch_valid, fetch_tid, fetch_pc
  );

  modport slave (
    input  stall, thread_en, redirect_valid, redirect_tid, redirect_pc,
    output fetch_valid, fetch_tid, fetch_pc
  );

endinterface

// File: rtl/pc_unit_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module pc_unit_rr_arbiter
  import pc_unit_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = tid_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Per-thread PC array with round-robin fetch issue and execute redirects.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               NUM_THREADS = DEF_NUM_THREADS,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               INC         = DEF_INC
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);

  localparam int TID_W = tid_width(NUM_THREADS);

  typedef logic [WIDTH-1:0] pc_t;
  typedef logic [TID_W-1:0] tid_t;

  localparam pc_t INC_V      = pc_t'(INC);
  localparam pc_t ALIGN_MASK = pc_t'(align_mask(INC));

  pc_t  pc [NUM_THREADS];
  tid_t ptr;
  logic fetch_valid_q;
  tid_t fetch_tid_q;
  pc_t  fetch_pc_q;

  logic gnt_valid;
  tid_t gnt_idx;
  logic redirect_hit;
  logic redirect_conflict;
  logic issue;
  pc_t  redirect_aligned;
  tid_t ptr_next;

  pc_unit_rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .req       (bus.thread_en),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A redirect landing on the thread being picked suppresses the issue so the
  // stale PC never reaches fetch; the pointer stays so that thread goes next.
  always_comb begin
    redirect_hit      = bus.redirect_valid && (int'(bus.redirect_tid) < NUM_THREADS);
    redirect_conflict = redirect_hit && gnt_valid && (bus.redirect_tid == gnt_idx);
    issue             = !bus.stall && gnt_valid && !redirect_conflict;
    redirect_aligned  = bus.redirect_pc & ALIGN_MASK;
    ptr_next          = tid_t'((int'(gnt_idx) + 1) % NUM_THREADS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_PC;
      ptr           <= '0;
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (redirect_hit && (int'(bus.redirect_tid) == t)) begin
          pc[t] <= redirect_aligned;
        end else if (issue && (int'(gnt_idx) == t)) begin
          pc[t] <= pc[t] + INC_V;
        end
      end
      fetch_valid_q <= issue;
      if (issue) begin
        ptr         <= ptr_next;
        fetch_tid_q <= gnt_idx;
        fetch_pc_q  <= pc[gnt_idx];
      end
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_tid   = fetch_tid_q;
  assign bus.fetch_pc    = fetch_pc_q;

endmodule
